// File: rtl/countdown_sequencer.sv
// countdown_sequencer
//   Counts down a BCD MM:SS value handed over by the time-set service at one
//   step per TICK_DIV clocks. The centre pushbutton starts, pauses, resumes
//   and acknowledges expiry. The display value and blank control are
//   registered and drive the seven-segment driver directly.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   enable     service select; low forces IDLE
//   set_done   time-set service has finished (level)
//   set_time   BCD MM:SS from time-set
//   push_c     single-cycle pushbutton pulse
//   disp_time  BCD value to display (current count)
//   disp_blank 1 = blank all digits (blink phase while expired)
//   running    1 while counting
//   expired    one-cycle pulse when the count reaches 0000
//   state      IDLE=0, LOAD=1, RUN=2, PAUSE=3, DONE=4
module countdown_sequencer #(
  parameter int TICK_DIV  = 100000000,
  parameter int BLINK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        set_done,
  input  logic [15:0] set_time,
  input  logic        push_c,
  output logic [15:0] disp_time,
  output logic        disp_blank,
  output logic        running,
  output logic        expired,
  output logic [2:0]  state
);

  localparam int PW = (TICK_DIV  > 2) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_reg,   state_next;
  logic [15:0]     count_reg,   count_next;
  logic [PW-1:0]   presc_reg,   presc_next;
  logic [BW-1:0]   blink_reg,   blink_next;
  logic            blank_reg,   blank_next;
  logic            expired_reg, expired_next;
  logic            running_reg, running_next;

  logic [15:0]     sanitized;
  logic [15:0]     dec_val;
  logic            tick;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second BCD decrement with borrow chain; seconds tens wraps to 5.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] s1, s10, m1, m10;
    s1  = c[3:0];
    s10 = c[7:4];
    m1  = c[11:8];
    m10 = c[15:12];
    if (s1 != 4'd0) begin
      s1 = s1 - 4'd1;
    end else begin
      s1 = 4'd9;
      if (s10 != 4'd0) begin
        s10 = s10 - 4'd1;
      end else begin
        s10 = 4'd5;
        if (m1 != 4'd0) begin
          m1 = m1 - 4'd1;
        end else begin
          m1  = 4'd9;
          m10 = m10 - 4'd1;
        end
      end
    end
    return {m10, m1, s10, s1};
  endfunction

  assign sanitized = {clamp_digit(set_time[15:12], 4'd9),
                      clamp_digit(set_time[11:8],  4'd9),
                      clamp_digit(set_time[7:4],   4'd5),
                      clamp_digit(set_time[3:0],   4'd9)};

  // A decrement is never issued from 0000.
  assign dec_val = (count_reg == 16'h0000) ? 16'h0000 : bcd_dec(count_reg);
  assign tick    = (presc_reg == PW'(TICK_DIV - 1));

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    presc_next   = presc_reg;
    blink_next   = blink_reg;
    blank_next   = blank_reg;
    expired_next = 1'b0;

    if (!enable) begin
      state_next = S_IDLE;
      presc_next = '0;
      blink_next = '0;
      blank_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (set_done && push_c) state_next = S_LOAD;
        end
        S_LOAD: begin
          count_next = sanitized;
          presc_next = '0;
          if (sanitized == 16'h0000) begin
            state_next   = S_DONE;
            expired_next = 1'b1;
            blink_next   = '0;
            blank_next   = 1'b0;
          end else begin
            state_next = S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            presc_next = '0;
            count_next = dec_val;
            // Reaching zero outranks a coincident pause request.
            if (dec_val == 16'h0000) begin
              state_next   = S_DONE;
              expired_next = 1'b1;
              blink_next   = '0;
              blank_next   = 1'b0;
            end else if (push_c) begin
              state_next = S_PAUSE;
            end
          end else if (push_c) begin
            // Prescaler frozen so the partial second survives the pause.
            state_next = S_PAUSE;
          end else begin
            presc_next = presc_reg + 1'b1;
          end
        end
        S_PAUSE: begin
          if (push_c) state_next = S_RUN;
        end
        S_DONE: begin
          if (push_c) begin
            state_next = S_IDLE;
            blink_next = '0;
            blank_next = 1'b0;
          end else if (blink_reg == BW'(BLINK_DIV - 1)) begin
            blink_next = '0;
            blank_next = ~blank_reg;
          end else begin
            blink_next = blink_reg + 1'b1;
          end
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end

    running_next = (state_next == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_IDLE;
      count_reg   <= 16'h0000;
      presc_reg   <= '0;
      blink_reg   <= '0;
      blank_reg   <= 1'b0;
      expired_reg <= 1'b0;
      running_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      presc_reg   <= presc_next;
      blink_reg   <= blink_next;
      blank_reg   <= blank_next;
      expired_reg <= expired_next;
      running_reg <= running_next;
    end
  end

  assign disp_time  = count_reg;
  assign disp_blank = blank_reg;
  assign running    = running_reg;
  assign expired    = expired_reg;
  assign state      = state_reg;

endmodule
